// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU boot status
// of the program loader, grouped as one bus.
interface program_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        RxData;
   logic              RxValid;
   logic              RxReady;
   logic              Restart;
   logic [ADDR_W-1:0] MemAddr;
   logic [15:0]       MemData;
   logic              MemWE;
   logic              CpuResetN;
   logic              LoadDone;
   logic              LoadError;

   modport master (
      output RxData, RxValid, Restart,
      input  RxReady, MemAddr, MemData, MemWE, CpuResetN, LoadDone, LoadError
   );

   modport slave (
      input  RxData, RxValid, Restart,
      output RxReady, MemAddr, MemData, MemWE, CpuResetN, LoadDone, LoadError
   );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: assembles big-endian words from a byte
// stream, writes them from address 0 and releases the CPU once the XOR checksum matches.
module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   program_loader_if.slave  io_ldr
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [7:0]        r_len_hi;
   logic [15:0]       r_remaining;
   logic [7:0]        r_hi;
   logic [7:0]        r_xor;
   logic [ADDR_W-1:0] r_addr;

   logic              r_rx_ready;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_data;
   logic              r_mem_we;
   logic              r_cpu_rst_n;
   logic              r_load_done;
   logic              r_load_error;

   logic              w_xfer;
   logic [16:0]       w_len_full;
   logic              w_rx_ready_nxt;

   assign w_xfer     = io_ldr.RxValid && r_rx_ready;
   assign w_len_full = {1'b0, r_len_hi, io_ldr.RxData};

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= S_LEN_HI;
      else        r_state <= w_state_nxt;
   end

   // Restart overrides everything, including a byte offered in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (io_ldr.Restart) begin
         w_state_nxt = S_LEN_HI;
      end else begin
         case (r_state)
            S_LEN_HI:  if (w_xfer) w_state_nxt = S_LEN_LO;
            S_LEN_LO: begin
               if (w_xfer) begin
                  if (w_len_full > MAX_WORDS)  w_state_nxt = S_ERROR;
                  else if (w_len_full == '0)   w_state_nxt = S_CHECK;
                  else                         w_state_nxt = S_DATA_HI;
               end
            end
            S_DATA_HI: if (w_xfer) w_state_nxt = S_DATA_LO;
            S_DATA_LO: if (w_xfer) w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = (r_remaining == 16'd1) ? S_CHECK : S_DATA_HI;
            S_CHECK: begin
               if (w_xfer) w_state_nxt = (io_ldr.RxData == r_xor) ? S_DONE : S_ERROR;
            end
            S_DONE:    w_state_nxt = S_DONE;
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = S_LEN_HI;
         endcase
      end
   end

   assign w_rx_ready_nxt = w_state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                               S_DATA_LO, S_CHECK};

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_len_hi     <= '0;
         r_remaining  <= '0;
         r_hi         <= '0;
         r_xor        <= '0;
         r_addr       <= '0;
         r_rx_ready   <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_mem_we     <= 1'b0;
         r_cpu_rst_n  <= 1'b0;
         r_load_done  <= 1'b0;
         r_load_error <= 1'b0;
      end else begin
         r_rx_ready   <= w_rx_ready_nxt;
         r_mem_we     <= (w_state_nxt == S_WRITE);
         r_cpu_rst_n  <= (w_state_nxt == S_DONE);
         r_load_done  <= (w_state_nxt == S_DONE);
         r_load_error <= (w_state_nxt == S_ERROR);
         if (io_ldr.Restart) begin
            r_addr <= '0;
         end else begin
            case (r_state)
               S_LEN_HI: begin
                  if (w_xfer) begin
                     r_len_hi <= io_ldr.RxData;
                     r_xor    <= io_ldr.RxData;
                  end
               end
               S_LEN_LO: begin
                  if (w_xfer) begin
                     r_remaining <= {r_len_hi, io_ldr.RxData};
                     r_xor       <= r_xor ^ io_ldr.RxData;
                     r_addr      <= '0;
                  end
               end
               S_DATA_HI: begin
                  if (w_xfer) begin
                     r_hi  <= io_ldr.RxData;
                     r_xor <= r_xor ^ io_ldr.RxData;
                  end
               end
               S_DATA_LO: begin
                  if (w_xfer) begin
                     r_xor      <= r_xor ^ io_ldr.RxData;
                     r_mem_data <= {r_hi, io_ldr.RxData};
                     r_mem_addr <= r_addr;
                  end
               end
               S_WRITE: begin
                  r_addr      <= r_addr + 1'b1;
                  r_remaining <= r_remaining - 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign io_ldr.RxReady   = r_rx_ready;
   assign io_ldr.MemAddr   = r_mem_addr;
   assign io_ldr.MemData   = r_mem_data;
   assign io_ldr.MemWE     = r_mem_we;
   assign io_ldr.CpuResetN = r_cpu_rst_n;
   assign io_ldr.LoadDone  = r_load_done;
   assign io_ldr.LoadError = r_load_error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of byte streams plus hand-written restart and
// full-memory sequences; memory writes are checked against a scoreboard queue.
module tb_program_loader;

   localparam int ADDR_W = 8;

   logic Clock = 1'b0;
   logic Reset = 1'b0;

   program_loader_if #(.ADDR_W(ADDR_W)) ifc ();

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .io_ldr (ifc)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   typedef struct {
      logic [7:0] b [8];
      int         len;
      bit         gaps;
      bit         exp_done;
      bit         exp_err;
      int         exp_writes;
   } vec_t;

   wr_t  exp_q [$];
   vec_t vecs [5];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_we  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every MemWE pulse must match the head of the scoreboard.
   always @(negedge Clock) begin
      if (Reset && ifc.MemWE) begin
         wr_t e;
         n_we++;
         check("rxready_in_write", ifc.RxReady, 1'b0);
         check("cpureset_during_load", ifc.CpuResetN, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(ifc.MemAddr), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(ifc.MemAddr), 32'(e.addr));
            check("write_data", 32'(ifc.MemData), 32'(e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      @(negedge Clock);
      ifc.RxData  = b;
      ifc.RxValid = 1'b1;
      while (!ifc.RxReady && t < 50) begin
         @(negedge Clock);
         t++;
      end
      if (t >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rxready_timeout: got 0, expected 1 within 50 cycles");
         ifc.RxValid = 1'b0;
      end else begin
         @(posedge Clock);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge Clock);
         ifc.RxValid = 1'b0;
      end
   endtask

   task automatic restart_pulse();
      @(negedge Clock);
      ifc.RxValid = 1'b0;
      ifc.Restart = 1'b1;
      @(negedge Clock);
      ifc.Restart = 1'b0;
      check("restart_done", ifc.LoadDone, 1'b0);
      check("restart_err", ifc.LoadError, 1'b0);
      check("restart_cpurst", ifc.CpuResetN, 1'b0);
      check("restart_ready", ifc.RxReady, 1'b1);
   endtask

   task automatic expect_end(input string tag, input bit done, input bit err,
                             input int writes, input int we0);
      idle(4);
      check({tag, "_done"}, ifc.LoadDone, done);
      check({tag, "_err"}, ifc.LoadError, err);
      check({tag, "_cpurst"}, ifc.CpuResetN, done);
      check({tag, "_ready"}, ifc.RxReady, 1'b0);
      check({tag, "_nwrites"}, 32'(n_we - we0), 32'(writes));
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Expected writes are queued as the LO byte of each word is offered.
   task automatic run_vec(input vec_t v);
      int n;
      wr_t e;
      n = {v.b[0], v.b[1]};
      for (int i = 0; i < v.len; i++) begin
         if (i >= 3 && ((i - 3) % 2) == 0 && ((i - 3) / 2) < n && n <= (1 << ADDR_W)) begin
            e.addr = ADDR_W'((i - 3) / 2);
            e.data = {v.b[i-1], v.b[i]};
            exp_q.push_back(e);
         end
         if (v.gaps) idle($urandom_range(0, 3));
         send_byte(v.b[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int we0;
      logic [7:0] x;
      wr_t e;

      vecs[0].b = '{8'h00, 8'h02, 8'h51, 8'h23, 8'h8A, 8'h04, 8'hFE, 8'h00};
      vecs[0].len = 7; vecs[0].gaps = 0; vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_writes = 2;
      vecs[1].b = '{8'h00, 8'h02, 8'h51, 8'h23, 8'h8A, 8'h04, 8'hFF, 8'h00};
      vecs[1].len = 7; vecs[1].gaps = 0; vecs[1].exp_done = 0; vecs[1].exp_err = 1; vecs[1].exp_writes = 2;
      vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2].len = 3; vecs[2].gaps = 0; vecs[2].exp_done = 1; vecs[2].exp_err = 0; vecs[2].exp_writes = 0;
      vecs[3].b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3].len = 2; vecs[3].gaps = 0; vecs[3].exp_done = 0; vecs[3].exp_err = 1; vecs[3].exp_writes = 0;
      vecs[4].b = '{8'h00, 8'h02, 8'h51, 8'h23, 8'h8A, 8'h04, 8'hFE, 8'h00};
      vecs[4].len = 7; vecs[4].gaps = 1; vecs[4].exp_done = 1; vecs[4].exp_err = 0; vecs[4].exp_writes = 2;

      ifc.RxData  = 8'h00;
      ifc.RxValid = 1'b0;
      ifc.Restart = 1'b0;

      repeat (2) @(negedge Clock);
      check("rst_ready", ifc.RxReady, 1'b0);
      check("rst_memaddr", 32'(ifc.MemAddr), 32'd0);
      check("rst_memdata", 32'(ifc.MemData), 32'd0);
      check("rst_memwe", ifc.MemWE, 1'b0);
      check("rst_cpurst", ifc.CpuResetN, 1'b0);
      check("rst_done", ifc.LoadDone, 1'b0);
      check("rst_err", ifc.LoadError, 1'b0);
      Reset = 1'b1;

      for (int k = 0; k < 5; k++) begin
         we0 = n_we;
         run_vec(vecs[k]);
         expect_end($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err,
                    vecs[k].exp_writes, we0);
         restart_pulse();
      end

      // Restart coincident with the LO byte 0x23: that byte must be dropped.
      we0 = n_we;
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h51);
      @(negedge Clock);
      ifc.RxData  = 8'h23;
      ifc.RxValid = 1'b1;
      ifc.Restart = 1'b1;
      @(negedge Clock);
      ifc.Restart = 1'b0;
      ifc.RxValid = 1'b0;
      check("midrestart_nowrite", ifc.MemWE, 1'b0);
      run_vec(vecs[0]);
      expect_end("midrestart", 1'b1, 1'b0, 2, we0);
      restart_pulse();

      // Restart during a WRITE cycle: the write still lands, address restarts at 0.
      we0 = n_we;
      e.addr = '0; e.data = 16'h1234;
      exp_q.push_back(e);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge Clock);
      ifc.RxValid = 1'b0;
      ifc.Restart = 1'b1;
      @(negedge Clock);
      ifc.Restart = 1'b0;
      check("wrrestart_memwe", ifc.MemWE, 1'b0);
      check("wrrestart_ready", ifc.RxReady, 1'b1);
      run_vec(vecs[0]);
      expect_end("wrrestart", 1'b1, 1'b0, 3, we0);
      restart_pulse();

      // Exactly fill memory: N = 2^ADDR_W words.
      we0 = n_we;
      x = 8'h01 ^ 8'h00;
      send_byte(8'h01);
      send_byte(8'h00);
      for (int k = 0; k < (1 << ADDR_W); k++) begin
         e.addr = ADDR_W'(k);
         e.data = {8'(k), ~8'(k)};
         exp_q.push_back(e);
         x = x ^ e.data[15:8] ^ e.data[7:0];
         send_byte(e.data[15:8]);
         send_byte(e.data[7:0]);
      end
      send_byte(x);
      expect_end("fullmem", 1'b1, 1'b0, 1 << ADDR_W, we0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
